if_id_pipe_reg: RTL

//  - Fetch-to-decode stage register, directly downstream of the PC register (DFlipFlop-based).
//  - Captures {pc, instr} from fetch and presents it to decode with a valid/ready handshake.
//  - Supports stall via backpressure and a synchronous flush for taken branches/jumps.
//  - Flush or reset inserts a bubble: the RISC-V NOP (addi x0,x0,0).

---
 rtl/if_id_pipe_reg.sv | 100 ++++++++++
 1 files changed

// File: rtl/if_id_pipe_reg.sv
// IF/ID stage register: holds {pc, instr} for decode behind a valid/ready handshake, with flush-to-NOP.
// Build option IF_ID_SKID_BUFFER_EN adds one skid entry and makes in_ready a registered output.
module if_id_pipe_reg #(
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr
);

    logic in_fire;
    logic out_fire;

    assign out_fire = out_valid && out_ready;

`ifdef IF_ID_SKID_BUFFER_EN

    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic            out_free;

    // in_ready comes straight from a flop, so fetch never sees a combinational path from decode
    assign in_ready = !skid_valid;
    assign in_fire  = in_valid && in_ready;
    assign out_free = !out_valid || out_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_instr  <= NOP_INSTR;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= NOP_INSTR;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_instr  <= NOP_INSTR;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                // skid is older than anything fetch can offer, and in_ready is low here anyway
                out_valid  <= 1'b1;
                out_pc     <= skid_pc;
                out_instr  <= skid_instr;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                out_valid <= 1'b1;
                out_pc    <= in_pc;
                out_instr <= in_instr;
            end else if (out_valid) begin
                out_valid <= 1'b0;
                out_instr <= NOP_INSTR;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_pc    <= in_pc;
            skid_instr <= in_instr;
        end
    end

`else

    // Flush drops whatever fetch offers, so the stage is always ready during a flush
    assign in_ready = flush || !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= NOP_INSTR;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= NOP_INSTR;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            out_instr <= in_instr;
        end else if (out_fire) begin
            // pc is left as-is on drain; only the instruction reverts to the bubble
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
        end
    end

`endif

endmodule
